// File: rtl/store_buffer_unit_pkg.sv
// Shared types for the store buffer: size codes, FSM encoding, queue entry layout
// and the byte-lane formatting / alignment helpers applied at enqueue.
package store_buffer_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} sbu_state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  // Little-endian: replicate the datum across lanes so the memory only needs byte enables
  function automatic lane_t fmt_lane(input logic [1:0] size, input logic [1:0] lane,
                                     input logic [31:0] data);
    lane_t r;
    r = '0;
    case (size)
      SIZE_BYTE: begin r.wdata = {4{data[7:0]}};  r.be = 4'b0001 << lane; end
      SIZE_HALF: begin r.wdata = {2{data[15:0]}}; r.be = lane[1] ? 4'b1100 : 4'b0011; end
      SIZE_WORD: begin r.wdata = data;            r.be = 4'b1111; end
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lane[0];
      SIZE_WORD: return lane == 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_unit_if.sv
// Datapath-side store handshake plus memory write channel and status of the store buffer.
interface store_buffer_unit_if #(parameter int CNT_W = 3);
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_size;
  logic             mem_req;
  logic             mem_ack;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             busy;
  logic             misalign_err;
  logic [CNT_W-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, misalign_err, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, misalign_err, count
  );
endinterface

// File: rtl/store_buffer_unit_fifo.sv
// Synchronous FIFO holding formatted store entries; head is always visible on dout.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  // A full queue refuses pushes even when the head pops in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = cnt_q == CNT_W'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: checks alignment, formats lanes, queues stores and drains them in order
// to data memory through a two-state req/ack FSM.
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_unit_if.slave sb
);
  sbu_state_e       state_q;
  logic             misalign_q, misalign_d;
  sb_entry_t        head, push_entry;
  lane_t            lane_fmt;
  logic             full, empty, accept, legal, push, pop;
  logic [CNT_W-1:0] cnt;

  assign lane_fmt   = fmt_lane(sb.st_size, sb.st_addr[1:0], sb.st_data);
  assign legal      = is_aligned(sb.st_size, sb.st_addr[1:0]);
  assign accept     = sb.st_valid && !full;
  // Illegal stores are still consumed so the datapath never stalls on them
  assign push       = accept && legal;
  assign misalign_d = accept && !legal;
  assign pop        = (state_q == REQ) && sb.mem_ack;
  assign push_entry = '{waddr: sb.st_addr[31:2], wdata: lane_fmt.wdata, be: lane_fmt.be};

  store_fifo #(.DEPTH(DEPTH), .W($bits(sb_entry_t)), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      case (state_q)
        IDLE:    if (cnt != '0) state_q <= REQ;
        REQ:     if (sb.mem_ack && !(cnt > CNT_W'(1))) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sb.st_ready     = !full;
  assign sb.mem_req      = state_q == REQ;
  assign sb.mem_addr     = (state_q == REQ) ? {head.waddr, 2'b00} : 32'h0;
  assign sb.mem_wdata    = (state_q == REQ) ? head.wdata : 32'h0;
  assign sb.mem_be       = (state_q == REQ) ? head.be : 4'h0;
  assign sb.busy         = (state_q == REQ) || !empty;
  assign sb.misalign_err = misalign_q;
  assign sb.count        = cnt;
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit: reset, lane formatting, misalignment, full queue,
// back-to-back drain and reset in the middle of a transfer.
module tb_store_buffer_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  store_buffer_unit_if #(.CNT_W(3)) sbif ();
  store_buffer_unit #(.DEPTH(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .sb(sbif.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    sbif.st_valid = v;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_size  = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    sbif.mem_ack = 1'b0;
    #12;
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", sbif.count); end
    total++; if (sbif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", sbif.busy); end
    total++; if (sbif.misalign_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", sbif.misalign_err); end
    total++; if (sbif.st_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", sbif.st_ready); end
    total++; if ({sbif.mem_addr, sbif.mem_wdata, sbif.mem_be} !== 68'h0) begin
      bad++; $display("FAIL rst_bus got=%h/%h/%b exp=0", sbif.mem_addr, sbif.mem_wdata, sbif.mem_be); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw();
    drive(1'b1, 32'h1000, 32'hDEADBEEF, 2'b10);
    total++; if (sbif.st_ready !== 1'b1) begin bad++; $display("FAIL sw_ready got=%0b exp=1", sbif.st_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    total++; if (sbif.count !== 3'd1) begin bad++; $display("FAIL sw_count got=%0d exp=1", sbif.count); end
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL sw_req_early got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.busy !== 1'b1) begin bad++; $display("FAIL sw_busy got=%0b exp=1", sbif.busy); end
    tick();
    total++; if (sbif.mem_addr !== 32'h1000) begin bad++; $display("FAIL sw_addr got=%h exp=00001000", sbif.mem_addr); end
    total++; if (sbif.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", sbif.mem_wdata); end
    total++; if (sbif.mem_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", sbif.mem_be); end
    for (int i = 0; i < 3; i++) begin
      total++; if (sbif.mem_req !== 1'b1) begin bad++; $display("FAIL sw_req_hold[%0d] got=%0b exp=1", i, sbif.mem_req); end
      total++; if (sbif.mem_addr !== 32'h1000) begin bad++; $display("FAIL sw_addr_hold[%0d] got=%h exp=00001000", i, sbif.mem_addr); end
      if (i == 2) sbif.mem_ack = 1'b1;
      tick();
    end
    sbif.mem_ack = 1'b0;
    total++; if (sbif.busy !== 1'b0) begin bad++; $display("FAIL sw_busy_end got=%0b exp=0", sbif.busy); end
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL sw_req_end got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.mem_be !== 4'b0000) begin bad++; $display("FAIL sw_be_idle got=%b exp=0000", sbif.mem_be); end
  endtask

  task automatic test_lanes();
    drive(1'b1, 32'h2003, 32'h000000AB, 2'b00);
    tick();
    drive(1'b1, 32'h2002, 32'h00001234, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    total++; if (sbif.count !== 3'd2) begin bad++; $display("FAIL ln_count got=%0d exp=2", sbif.count); end
    total++; if (sbif.mem_addr !== 32'h2000) begin bad++; $display("FAIL sb_addr got=%h exp=00002000", sbif.mem_addr); end
    total++; if (sbif.mem_wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", sbif.mem_wdata); end
    total++; if (sbif.mem_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", sbif.mem_be); end
    sbif.mem_ack = 1'b1;
    tick();
    total++; if (sbif.mem_req !== 1'b1) begin bad++; $display("FAIL sh_req got=%0b exp=1", sbif.mem_req); end
    total++; if (sbif.mem_wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%h exp=12341234", sbif.mem_wdata); end
    total++; if (sbif.mem_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", sbif.mem_be); end
    tick();
    sbif.mem_ack = 1'b0;
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL ln_req_end got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.count !== 3'd0) begin bad++; $display("FAIL ln_count_end got=%0d exp=0", sbif.count); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2] = '{32'h3001, 32'h3000};
    logic [1:0]  sizes [2] = '{2'b01, 2'b11};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, addrs[i], 32'h55AA55AA, sizes[i]);
      total++; if (sbif.st_ready !== 1'b1) begin bad++; $display("FAIL mis_ready[%0d] got=%0b exp=1", i, sbif.st_ready); end
      tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      total++; if (sbif.misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse[%0d] got=%0b exp=1", i, sbif.misalign_err); end
      total++; if (sbif.count !== 3'd0) begin bad++; $display("FAIL mis_count[%0d] got=%0d exp=0", i, sbif.count); end
      tick();
      total++; if (sbif.misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear[%0d] got=%0b exp=0", i, sbif.misalign_err); end
      total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL mis_req[%0d] got=%0b exp=0", i, sbif.mem_req); end
    end
  endtask

  task automatic test_full_drain();
    sbif.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 2'b10);
      total++; if (sbif.st_ready !== (i < 4)) begin bad++; $display("FAIL full_ready[%0d] got=%0b exp=%0b", i, sbif.st_ready, i < 4); end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    total++; if (sbif.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", sbif.count); end
    total++; if (sbif.st_ready !== 1'b0) begin bad++; $display("FAIL full_ready_hold got=%0b exp=0", sbif.st_ready); end
    sbif.mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (sbif.mem_req !== 1'b1) begin bad++; $display("FAIL drain_req[%0d] got=%0b exp=1", k, sbif.mem_req); end
      total++; if (sbif.mem_addr !== 32'h100 + 32'(4 * k)) begin bad++; $display("FAIL drain_addr[%0d] got=%h exp=%h", k, sbif.mem_addr, 32'h100 + 32'(4 * k)); end
      total++; if (sbif.mem_wdata !== 32'(k + 1)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, sbif.mem_wdata, 32'(k + 1)); end
      tick();
    end
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL drain_idle got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", sbif.count); end
    tick();
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored got=%0b exp=0", sbif.mem_req); end
    sbif.mem_ack = 1'b0;
  endtask

  task automatic test_full_pop_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
      tick();
    end
    drive(1'b1, 32'h300, 32'hBAD, 2'b10);
    sbif.mem_ack = 1'b1;
    total++; if (sbif.st_ready !== 1'b0) begin bad++; $display("FAIL fp_ready got=%0b exp=0", sbif.st_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    sbif.mem_ack = 1'b0;
    total++; if (sbif.count !== 3'd3) begin bad++; $display("FAIL fp_count got=%0d exp=3", sbif.count); end
    total++; if (sbif.mem_addr !== 32'h204) begin bad++; $display("FAIL fp_head got=%h exp=00000204", sbif.mem_addr); end
    reset = 1'b1;
    #1;
    total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%0b exp=0", sbif.mem_req); end
    total++; if (sbif.count !== 3'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", sbif.count); end
    total++; if (sbif.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0b exp=0", sbif.busy); end
    tick();
    reset = 1'b0;
    sbif.mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (sbif.mem_req !== 1'b0) begin bad++; $display("FAIL post_rst_req[%0d] got=%0b exp=0", i, sbif.mem_req); end
    end
    sbif.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lanes();
    test_misalign();
    test_full_drain();
    test_full_pop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
